pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Sequences the PLL's reset input and consumes its extlock output, so it sits at the control end of the PLL's reset/lock interface.
- Pulses PLL reset, waits for lock with a timeout and bounded retries, and qualifies lock as stable before releasing the system reset.
- Re-sequences the PLL on lock loss or on software request.
- Runs on the free-running reference clock, never on a PLL output.

Parameters:
- RST_PULSE_CYC, 24: cycles pll_reset_o is held high per reset attempt (1 us at 24 MHz).
- LOCK_TIMEOUT_CYC, 24000: cycles allowed in WAIT_LOCK before an attempt counts as failed.
- LOCK_STABLE_CYC, 256: consecutive synchronized-lock-high cycles required before release.
- MAX_RETRY, 3: failed attempts allowed before entering FAIL; range 1..3.
- CNT_W, 16: width of the shared cycle counter; must hold max(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC).

Ports:
- clk  in  1  free-running reference clock.
- rst_n  in  1  asynchronous active-low reset.
- pll_extlock_i  in  1  PLL lock flag; asynchronous to clk.
- relock_req_i  in  1  single-cycle request to re-sequence the PLL.
- pll_reset_o  out  1  drives the PLL reset input; active high.
- sys_rst_n_o  out  1  downstream system reset; active low.
- locked_o  out  1  qualified lock indication.
- fail_o  out  1  retry budget exhausted.
- retry_cnt_o  out  2  failed attempts in the current sequence.
- loss_cnt_o  out  8  lock-loss event count; see Optional Feature.

Behaviour:
- Synchronization: pll_extlock_i passes through a 2-flop synchronizer to form lock_s, giving 2 cycles of latency. Synchronizer flops reset to 0. No other logic samples pll_extlock_i directly.
- State machine and outputs: states are RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL. All outputs are decoded from the registered state and counters, so they are glitch-free and update on the same edge as the transition.
  - pll_reset_o = RESET_PLL or FAIL.
  - sys_rst_n_o = locked_o = RUN.
  - fail_o = FAIL.
- Reset values while rst_n is low: state RESET_PLL, counter 0, retry 0, pll_reset_o 1, sys_rst_n_o 0, locked_o 0, fail_o 0, retry_cnt_o 0, loss_cnt_o 0.
- Reset applies asynchronously at any point, including mid-sequence. After release, sequencing restarts from RESET_PLL with a full pulse.
- RESET_PLL: counter increments each cycle. At RST_PULSE_CYC-1, go to WAIT_LOCK and clear the counter. The pulse is exactly RST_PULSE_CYC cycles.
- WAIT_LOCK:
  - If lock_s is 1, go to STABLE and clear the counter.
  - Else, when the counter reaches LOCK_TIMEOUT_CYC-1, increment retry. If the new retry equals MAX_RETRY, go to FAIL; otherwise go to RESET_PLL. Either way, clear the counter.
  - If lock_s and timeout occur in the same cycle, lock wins.
- STABLE:
  - If lock_s is 0, go to WAIT_LOCK with the counter cleared, giving a fresh timeout. Retry is unchanged.
  - After LOCK_STABLE_CYC consecutive cycles with lock_s at 1, go to RUN and clear retry.
- RUN:
  - If lock_s is 0, this is a lock-loss event: go to RESET_PLL with retry cleared. sys_rst_n_o falls on that same edge, 3 cycles after the pll_extlock_i fall at worst.
  - relock_req_i has the same effect as lock loss but does not count as a loss event.
  - If both occur in the same cycle, count one loss.
- FAIL: sticky. pll_reset_o stays held high. relock_req_i goes to RESET_PLL with retry cleared; rst_n also exits FAIL.
- relock_req_i is ignored in RESET_PLL, WAIT_LOCK and STABLE.
- Counters: a single shared CNT_W-bit counter serves all timed states. Retry is 2 bits and never wraps, because FAIL is reached first.

Optional Feature:
- Macro: PLL_SUPV_LOSS_CNT_EN.
- Defined: loss_cnt_o is an 8-bit counter that increments on each RUN lock-loss event. It saturates at 255 and is cleared only by rst_n.
- Undefined: the counter is not built and loss_cnt_o is tied to 8'd0. The port list is identical in both builds.

Decomposition:
- Shared package/header pll_supv_pkg holds:
  - the state encoding localparams;
  - default timing constants for the 24 MHz reference;
  - reduced simulation timing values.
- Sub-module pll_lock_sync: a 2-flop synchronizer, reset to 0. Reused for any other asynchronous status bit.

Test Plan:
All scenarios use RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=50, LOCK_STABLE_CYC=8, MAX_RETRY=3.
1. Normal lock: release rst_n at t0; extlock rises at t0+20 -> pll_reset_o high for cycles 0..3 only; sys_rst_n_o and locked_o rise at t0+31 (±1 per synchronizer alignment); retry_cnt_o=0.
2. Never lock: hold extlock at 0 -> three 4-cycle reset pulses, retry_cnt_o steps 1 then 2; fail_o=1 and pll_reset_o held at 1 after 162 cycles; relock_req_i pulse -> RESET_PLL, fail_o=0, retry_cnt_o=0.
3. Glitch in STABLE: drop extlock for 1 cycle after 5 stable cycles -> back to WAIT_LOCK with sys_rst_n_o still 0; release requires 8 fresh stable cycles.
4. Loss in RUN: drop extlock -> sys_rst_n_o and locked_o fall within 3 cycles; 4-cycle pll_reset_o pulse; re-release once lock returns; with PLL_SUPV_LOSS_CNT_EN defined, loss_cnt_o=1.
5. Async reset mid-WAIT_LOCK: assert rst_n -> all outputs at reset values within the same cycle with no clock edge needed; after release, a full sequence restarts.
6. Simultaneous events and saturation: relock_req_i and lock loss in the same RUN cycle -> loss_cnt_o increments by exactly 1; 300 loss events -> loss_cnt_o=255; macro undefined -> loss_cnt_o always 0.

Source files
------------

// File: rtl/pll_supv_pkg.sv
// rtl/pll_supv_pkg.sv - state encoding and timing constants shared by the PLL lock supervisor
package pll_supv_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_supv_state_t;

    // 24 MHz reference clock defaults
    localparam int DEF_RST_PULSE_CYC    = 24;
    localparam int DEF_LOCK_TIMEOUT_CYC = 24000;
    localparam int DEF_LOCK_STABLE_CYC  = 256;
    localparam int DEF_MAX_RETRY        = 3;
    localparam int DEF_CNT_W            = 16;

    // Shortened timing for simulation
    localparam int SIM_RST_PULSE_CYC    = 4;
    localparam int SIM_LOCK_TIMEOUT_CYC = 50;
    localparam int SIM_LOCK_STABLE_CYC  = 8;
    localparam int SIM_MAX_RETRY        = 3;

endpackage

// File: rtl/pll_lock_sync.sv
// rtl/pll_lock_sync.sv - 2-flop synchronizer for asynchronous status bits, resets to 0
module pll_lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencing, lock qualification and system reset release
// Optional lock-loss counter enabled by defining PLL_SUPV_LOSS_CNT_EN.
module pll_lock_supervisor
    import pll_supv_pkg::*;
#(
    parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int MAX_RETRY        = DEF_MAX_RETRY,
    parameter int CNT_W            = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_extlock_i,
    input  logic       relock_req_i,
    output logic       pll_reset_o,
    output logic       sys_rst_n_o,
    output logic       locked_o,
    output logic       fail_o,
    output logic [1:0] retry_cnt_o,
    output logic [7:0] loss_cnt_o
);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRY);

    pll_supv_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic [1:0]       retry_inc;
    logic             lock_s;

    pll_lock_sync u_lock_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (pll_extlock_i),
        .dout (lock_s)
    );

    assign retry_inc = retry_q + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET_PLL;
            cnt_q   <= '0;
            retry_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        unique case (state_q)
            ST_RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                // Lock is tested first so it wins over a coincident timeout
                if (lock_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_RESET_PLL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    retry_d = 2'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!lock_s || relock_req_i) begin
                    state_d = ST_RESET_PLL;
                    retry_d = 2'd0;
                end
            end
            ST_FAIL: begin
                cnt_d = '0;
                if (relock_req_i) begin
                    state_d = ST_RESET_PLL;
                    retry_d = 2'd0;
                end
            end
            default: begin
                state_d = ST_RESET_PLL;
                cnt_d   = '0;
                retry_d = 2'd0;
            end
        endcase
    end

    always_comb begin
        pll_reset_o = (state_q == ST_RESET_PLL) || (state_q == ST_FAIL);
        sys_rst_n_o = (state_q == ST_RUN);
        locked_o    = (state_q == ST_RUN);
        fail_o      = (state_q == ST_FAIL);
        retry_cnt_o = retry_q;
    end

`ifdef PLL_SUPV_LOSS_CNT_EN
    logic       loss_evt;
    logic [7:0] loss_q;

    // A relock request coinciding with lock loss still counts as one loss
    assign loss_evt = (state_q == ST_RUN) && !lock_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_q <= 8'd0;
        end else if (loss_evt && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign loss_cnt_o = loss_q;
`else
    assign loss_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - scoreboard bench for pll_lock_supervisor with a behavioural model
module tb_pll_lock_supervisor;
    import pll_supv_pkg::*;

    localparam int RP = SIM_RST_PULSE_CYC;
    localparam int TO = SIM_LOCK_TIMEOUT_CYC;
    localparam int SC = SIM_LOCK_STABLE_CYC;
    localparam int MR = SIM_MAX_RETRY;

    typedef struct packed {
        logic       pll_reset;
        logic       sys_rst_n;
        logic       locked;
        logic       fail;
        logic [1:0] retry;
        logic [7:0] loss;
    } obs_t;

    localparam obs_t RESET_OBS = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_extlock_i;
    logic       relock_req_i;
    logic       pll_reset_o;
    logic       sys_rst_n_o;
    logic       locked_o;
    logic       fail_o;
    logic [1:0] retry_cnt_o;
    logic [7:0] loss_cnt_o;

    pll_lock_supervisor #(
        .RST_PULSE_CYC   (RP),
        .LOCK_TIMEOUT_CYC(TO),
        .LOCK_STABLE_CYC (SC),
        .MAX_RETRY       (MR),
        .CNT_W           (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_extlock_i(pll_extlock_i),
        .relock_req_i (relock_req_i),
        .pll_reset_o  (pll_reset_o),
        .sys_rst_n_o  (sys_rst_n_o),
        .locked_o     (locked_o),
        .fail_o       (fail_o),
        .retry_cnt_o  (retry_cnt_o),
        .loss_cnt_o   (loss_cnt_o)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: phase plus cycles spent in it, lock seen through a 2-deep history
    localparam int PH_RST = 0, PH_WAIT = 1, PH_STAB = 2, PH_RUN = 3, PH_FAIL = 4;
    int m_phase, m_age, m_retry, m_loss;
    bit m_hist[$];

    task automatic model_reset();
        m_phase = PH_RST;
        m_age   = 0;
        m_retry = 0;
        m_loss  = 0;
        m_hist  = {1'b0, 1'b0};
    endtask

    task automatic model_edge(input bit ext, input bit rq);
        bit lock;
        lock = m_hist.pop_front();
        m_hist.push_back(ext);
        case (m_phase)
            PH_RST: begin
                m_age++;
                if (m_age == RP) begin m_phase = PH_WAIT; m_age = 0; end
            end
            PH_WAIT: begin
                if (lock) begin
                    m_phase = PH_STAB; m_age = 0;
                end else begin
                    m_age++;
                    if (m_age == TO) begin
                        m_retry++;
                        m_age   = 0;
                        m_phase = (m_retry == MR) ? PH_FAIL : PH_RST;
                    end
                end
            end
            PH_STAB: begin
                if (!lock) begin
                    m_phase = PH_WAIT; m_age = 0;
                end else begin
                    m_age++;
                    if (m_age == SC) begin m_phase = PH_RUN; m_retry = 0; m_age = 0; end
                end
            end
            PH_RUN: begin
                if (!lock || rq) begin
                    if (!lock && m_loss < 255) m_loss++;
                    m_phase = PH_RST; m_retry = 0; m_age = 0;
                end
            end
            default: begin
                if (rq) begin m_phase = PH_RST; m_retry = 0; m_age = 0; end
            end
        endcase
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.pll_reset = (m_phase == PH_RST) || (m_phase == PH_FAIL);
        o.sys_rst_n = (m_phase == PH_RUN);
        o.locked    = (m_phase == PH_RUN);
        o.fail      = (m_phase == PH_FAIL);
        o.retry     = 2'(m_retry);
`ifdef PLL_SUPV_LOSS_CNT_EN
        o.loss      = 8'(m_loss);
`else
        o.loss      = 8'd0;
`endif
        return o;
    endfunction

    function automatic obs_t dut_obs();
        return '{pll_reset_o, sys_rst_n_o, locked_o, fail_o, retry_cnt_o, loss_cnt_o};
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got pll_reset=%0b sys_rst_n=%0b locked=%0b fail=%0b retry=%0d loss=%0d, want pll_reset=%0b sys_rst_n=%0b locked=%0b fail=%0b retry=%0d loss=%0d",
                     name, $time, act.pll_reset, act.sys_rst_n, act.locked, act.fail, act.retry, act.loss,
                     exp.pll_reset, exp.sys_rst_n, exp.locked, exp.fail, exp.retry, exp.loss);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d want %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: every output sample after an active edge is matched against the queued prediction
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) check("cycle", dut_obs(), exp_q.pop_front());
        end
    end

    task automatic tick(input bit e, input bit rq);
        pll_extlock_i = e;
        relock_req_i  = rq;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(e, rq);
        exp_q.push_back(model_obs());
        @(negedge clk);
        relock_req_i = 1'b0;
    endtask

    task automatic do_reset(input int cyc);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_obs(), RESET_OBS);
        model_reset();
        repeat (cyc) tick(1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int expect_loss;
        rst_n         = 1'b1;
        pll_extlock_i = 1'b0;
        relock_req_i  = 1'b0;
        model_reset();

        // Normal lock: extlock rises 20 cycles after release
        do_reset(3);
        first = -1;
        for (int k = 0; k < 45; k++) begin
            tick(k >= 20, 1'b0);
            if (first < 0 && sys_rst_n_o === 1'b1) first = k + 1;
        end
        check_val("release_cycle", (first >= 30 && first <= 32) ? 31 : first, 31);

        // Never lock: three attempts then sticky FAIL, relock exits
        do_reset(2);
        for (int k = 0; k < 170; k++) begin
            tick(1'b0, 1'b0);
            if (k == 160) check_val("fail_before_162", int'(fail_o), 0);
            if (k == 161) check_val("fail_at_162", int'(fail_o), 1);
        end
        check_val("fail_holds_pll_reset", int'(pll_reset_o), 1);
        tick(1'b0, 1'b1);
        check_val("fail_exit_retry", int'(retry_cnt_o), 0);
        check_val("fail_exit_fail", int'(fail_o), 0);

        // One-cycle glitch after 5 stable cycles restarts qualification
        do_reset(2);
        for (int k = 0; k < 24; k++) begin
            tick(k != 8, 1'b0);
            if (k == 18) check_val("glitch_no_early_release", int'(sys_rst_n_o), 0);
            if (k == 19) check_val("glitch_release", int'(sys_rst_n_o), 1);
        end

        // Lock loss in RUN, then lock returns
        tick(1'b0, 1'b0);
        repeat (25) tick(1'b1, 1'b0);

        // Async reset in the middle of WAIT_LOCK, then a full sequence
        do_reset(2);
        repeat (10) tick(1'b0, 1'b0);
        do_reset(1);
        repeat (40) tick(1'b1, 1'b0);

        // Loss events, half of them coinciding with a relock request
        for (int i = 0; i < 300; i++) begin
            repeat (20) tick(1'b1, 1'b0);
            if (i % 2 == 1) begin
                tick(1'b0, 1'b0);
                tick(1'b1, 1'b0);
                tick(1'b1, 1'b1);
            end else begin
                tick(1'b0, 1'b0);
            end
        end
`ifdef PLL_SUPV_LOSS_CNT_EN
        expect_loss = 255;
`else
        expect_loss = 0;
`endif
        check_val("loss_saturation", int'(loss_cnt_o), expect_loss);

        // Randomized runs of lock/unlock with sporadic relock requests
        for (int r = 0; r < 60; r++) begin
            bit v;
            int len;
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 80);
            for (int j = 0; j < len; j++) tick(v, $urandom_range(0, 19) == 0);
        end

        @(negedge clk);
        #1;
        check_val("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
